// File: rtl/hazard_scoreboard_unit_if.sv
// Decode/execute hazard bus. The master drives the pipeline status and the slave returns the stall and flush controls.
interface hazard_scoreboard_unit_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 16
);
    logic              MemReadE;
    logic              MulDivE;
    logic [REG_AW-1:0] RD_E;
    logic [REG_AW-1:0] Rs1_D;
    logic [REG_AW-1:0] Rs2_D;
    logic              UseRs1_D;
    logic              UseRs2_D;
    logic              PCSrcE;
    logic              PCWrite;
    logic              IF_ID_Write;
    logic              FlushD;
    logic              FlushE;
    logic              StallD;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output MemReadE, MulDivE, RD_E, Rs1_D, Rs2_D, UseRs1_D, UseRs2_D, PCSrcE,
        input  PCWrite, IF_ID_Write, FlushD, FlushE, StallD, stall_cycles
    );

    modport slave (
        input  MemReadE, MulDivE, RD_E, Rs1_D, Rs2_D, UseRs1_D, UseRs2_D, PCSrcE,
        output PCWrite, IF_ID_Write, FlushD, FlushE, StallD, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Per-register countdown scoreboard for load-use and mul/div hazards. Controls are combinational (zero latency);
// decode is held until each source operand can be forwarded, and a taken branch overrides any stall.
module hazard_scoreboard_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 3,
    parameter int PERF_W   = 16
) (
    input logic                     clk,
    input logic                     rst,
    hazard_scoreboard_unit_if.slave bus
);
    localparam int NREG    = 1 << REG_AW;
    localparam int MAX_LAT = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MD_LAT - 1);

    logic [CNT_W-1:0]  r_cnt [NREG];
    logic [PERF_W-1:0] r_stall_cycles;

    logic             w_long_e;
    logic [CNT_W-1:0] w_lat_init;
    logic             w_haz_rs1;
    logic             w_haz_rs2;
    logic             w_hazard;

    // The EX-stage producer is not in the scoreboard yet, so it is matched directly.
    assign w_long_e   = (bus.MemReadE | bus.MulDivE) & (bus.RD_E != '0);
    assign w_lat_init = bus.MemReadE ? LD_INIT : MD_INIT;
    assign w_haz_rs1  = bus.UseRs1_D & (bus.Rs1_D != '0) &
                        ((w_long_e & (bus.RD_E == bus.Rs1_D)) | (r_cnt[bus.Rs1_D] != '0));
    assign w_haz_rs2  = bus.UseRs2_D & (bus.Rs2_D != '0) &
                        ((w_long_e & (bus.RD_E == bus.Rs2_D)) | (r_cnt[bus.Rs2_D] != '0));
    assign w_hazard   = w_haz_rs1 | w_haz_rs2;

    always_comb begin
        bus.PCWrite     = 1'b1;
        bus.IF_ID_Write = 1'b1;
        bus.FlushD      = 1'b0;
        bus.FlushE      = 1'b0;
        bus.StallD      = 1'b0;
        if (rst) begin
            bus.PCWrite = 1'b1;
        end else if (bus.PCSrcE) begin
            bus.FlushD = 1'b1;
            bus.FlushE = 1'b1;
        end else if (w_hazard) begin
            bus.PCWrite     = 1'b0;
            bus.IF_ID_Write = 1'b0;
            bus.FlushE      = 1'b1;
            bus.StallD      = 1'b1;
        end
    end

    // Branches leave the counters alone: tracked producers are older than the branch.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst || i == 0) begin
                r_cnt[i] <= '0;
            end else if (w_long_e && bus.RD_E == REG_AW'(i)) begin
                r_cnt[i] <= w_lat_init;
            end else if (r_cnt[i] != '0) begin
                r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (bus.StallD && r_stall_cycles != {PERF_W{1'b1}}) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench: dut_a (LOAD_LAT=1, MD_LAT=3), dut_b (LOAD_LAT=3, MD_LAT=3, 2-bit perf counter) share one stimulus stream.
module tb_hazard_scoreboard_unit;
    localparam logic [4:0] NRM = 5'b11000;  // {PCWrite, IF_ID_Write, FlushD, FlushE, StallD}
    localparam logic [4:0] STL = 5'b00011;
    localparam logic [4:0] BRN = 5'b11110;

    typedef struct {
        bit          sel;
        string       name;
        logic [4:0]  ctl;
        logic [15:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(.REG_AW(5), .PERF_W(16)) ifa ();
    hazard_scoreboard_unit_if #(.REG_AW(5), .PERF_W(2))  ifb ();

    assign ifb.MemReadE = ifa.MemReadE;
    assign ifb.MulDivE  = ifa.MulDivE;
    assign ifb.RD_E     = ifa.RD_E;
    assign ifb.Rs1_D    = ifa.Rs1_D;
    assign ifb.Rs2_D    = ifa.Rs2_D;
    assign ifb.UseRs1_D = ifa.UseRs1_D;
    assign ifb.UseRs2_D = ifa.UseRs2_D;
    assign ifb.PCSrcE   = ifa.PCSrcE;

    hazard_scoreboard_unit #(.REG_AW(5), .LOAD_LAT(1), .MD_LAT(3), .PERF_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    hazard_scoreboard_unit #(.REG_AW(5), .LOAD_LAT(3), .MD_LAT(3), .PERF_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    task automatic step(input bit sel, input string nm, input bit r, input bit mr, input bit md,
                        input int rd, input int r1, input int r2, input bit u1, input bit u2,
                        input bit br, input logic [4:0] ctl, input int sc);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        ifa.MemReadE = mr;
        ifa.MulDivE  = md;
        ifa.RD_E     = 5'(rd);
        ifa.Rs1_D    = 5'(r1);
        ifa.Rs2_D    = 5'(r2);
        ifa.UseRs1_D = u1;
        ifa.UseRs2_D = u2;
        ifa.PCSrcE   = br;
        e.sel  = sel;
        e.name = nm;
        e.ctl  = ctl;
        e.sc   = 16'(sc);
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [4:0]  got_ctl;
        logic [15:0] got_sc;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.sel == 1'b0) begin
                    got_ctl = {ifa.PCWrite, ifa.IF_ID_Write, ifa.FlushD, ifa.FlushE, ifa.StallD};
                    got_sc  = ifa.stall_cycles;
                end else begin
                    got_ctl = {ifb.PCWrite, ifb.IF_ID_Write, ifb.FlushD, ifb.FlushE, ifb.StallD};
                    got_sc  = 16'(ifb.stall_cycles);
                end
                total++;
                if (got_ctl !== e.ctl) begin
                    bad++;
                    $display("FAIL %s ctl got=%b want=%b", e.name, got_ctl, e.ctl);
                end
                total++;
                if (got_sc !== e.sc) begin
                    bad++;
                    $display("FAIL %s stall_cycles got=%0d want=%0d", e.name, got_sc, e.sc);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        ifa.MemReadE = 1'b0; ifa.MulDivE = 1'b0; ifa.RD_E = '0;
        ifa.Rs1_D = '0; ifa.Rs2_D = '0; ifa.UseRs1_D = 1'b0; ifa.UseRs2_D = 1'b0; ifa.PCSrcE = 1'b0;

        //    sel name              rst mr md rd  r1  r2  u1 u2 br  ctl  sc
        step(0, "rst_hazard",       1, 1, 0, 5,  5,  0,  1, 0, 0, NRM, 0);
        step(0, "rst_branch",       1, 0, 0, 0,  0,  0,  0, 0, 1, NRM, 0);
        step(0, "ld_use_stall",     0, 1, 0, 5,  5,  2,  1, 1, 0, STL, 0);
        step(0, "ld_use_release",   0, 0, 0, 0,  5,  2,  1, 1, 0, NRM, 1);
        step(0, "x0_dest",          0, 1, 0, 0,  0,  0,  1, 1, 0, NRM, 1);
        step(0, "mul_rs2_0",        0, 0, 1, 9,  9,  9,  0, 1, 0, STL, 1);
        step(0, "mul_rs2_1",        0, 0, 0, 0,  9,  9,  0, 1, 0, STL, 2);
        step(0, "mul_rs2_2",        0, 0, 0, 0,  9,  9,  0, 1, 0, STL, 3);
        step(0, "mul_rs2_rel",      0, 0, 0, 0,  9,  9,  0, 1, 0, NRM, 4);
        step(0, "mul_nouse",        0, 0, 1, 9,  9,  9,  0, 0, 0, NRM, 4);
        step(0, "indep",            0, 0, 0, 0,  3,  4,  1, 1, 0, NRM, 4);
        step(0, "idle",             0, 0, 0, 0,  0,  0,  0, 0, 0, NRM, 4);
        step(0, "br_setup",         0, 0, 1, 4,  1,  2,  1, 1, 0, NRM, 4);
        step(0, "br_override",      0, 0, 0, 0,  4,  0,  1, 0, 1, BRN, 4);
        step(0, "br_keep_cnt",      0, 0, 0, 0,  4,  0,  1, 0, 0, STL, 4);
        step(0, "br_release",       0, 0, 0, 0,  4,  0,  1, 0, 0, NRM, 5);
        step(0, "ovw_mul",          0, 0, 1, 3,  1,  2,  1, 1, 0, NRM, 5);
        step(0, "ovw_load",         0, 1, 0, 3,  3,  0,  1, 0, 0, STL, 5);
        step(0, "ovw_release",      0, 0, 0, 0,  3,  0,  1, 0, 0, NRM, 6);
        step(0, "two_mul",          0, 0, 1, 10, 1,  2,  1, 1, 0, NRM, 6);
        step(0, "two_load",         0, 1, 0, 11, 10, 11, 1, 1, 0, STL, 6);
        step(0, "two_wait",         0, 0, 0, 0,  10, 11, 1, 1, 0, STL, 7);
        step(0, "two_release",      0, 0, 0, 0,  10, 11, 1, 1, 0, NRM, 8);
        step(0, "both_flags",       0, 1, 1, 12, 12, 0,  1, 0, 0, STL, 8);
        step(0, "both_flags_rel",   0, 0, 0, 0,  12, 0,  1, 0, 0, NRM, 9);
        step(0, "rst_setup",        0, 0, 1, 6,  1,  2,  1, 1, 0, NRM, 9);
        step(0, "rst_mid",          1, 0, 0, 0,  6,  0,  1, 0, 0, NRM, 9);
        step(0, "rst_after",        0, 0, 0, 0,  6,  0,  1, 0, 0, NRM, 0);
        step(1, "b_ld3_0",          0, 1, 0, 7,  7,  1,  1, 1, 0, STL, 0);
        step(1, "b_ld3_1",          0, 0, 0, 0,  7,  1,  1, 1, 0, STL, 1);
        step(1, "b_ld3_2",          0, 0, 0, 0,  7,  1,  1, 1, 0, STL, 2);
        step(1, "b_ld3_rel",        0, 0, 0, 0,  7,  1,  1, 1, 0, NRM, 3);
        step(1, "b_sat_0",          0, 1, 0, 7,  7,  1,  1, 1, 0, STL, 3);
        step(1, "b_sat_1",          0, 0, 0, 0,  7,  1,  1, 1, 0, STL, 3);
        step(1, "b_sat_2",          0, 0, 0, 0,  7,  1,  1, 1, 0, STL, 3);
        step(1, "b_sat_rel",        0, 0, 0, 0,  7,  1,  1, 1, 0, NRM, 3);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised load-use and long-latency hazard unit for the pipelined RISC-V core. It sits between decode and execute, replacing the fixed one-bubble load-use detector. A per-register countdown scoreboard tracks loads with configurable memory latency and multi-cycle mul/div results. It stalls decode until each operand can be forwarded, flushes on taken branches and counts stall cycles.

## Interface
- `REG_AW`, 5: register address width; the scoreboard holds 2^REG_AW entries.
- `LOAD_LAT`, 1: cycles a dependent instruction waits behind a load in EX; minimum 1.
- `MD_LAT`, 3: cycles a dependent instruction waits behind a mul/div in EX; minimum 1.
- `PERF_W`, 16: stall-cycle counter width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `MemReadE`  in  1  the EX-stage instruction is a load.
- `MulDivE`  in  1  the EX-stage instruction is a mul/div.
- `RD_E`  in  REG_AW  destination register of the EX-stage instruction.
- `Rs1_D`, `Rs2_D`  in  REG_AW  source registers of the decode-stage instruction.
- `UseRs1_D`, `UseRs2_D`  in  1  the decode-stage instruction actually reads Rs1/Rs2.
- `PCSrcE`  in  1  a branch or jump in EX is taken.
- `PCWrite`  out  1  PC enable.
- `IF_ID_Write`  out  1  IF/ID register enable.
- `FlushD`  out  1  clears IF/ID (inserts a NOP in decode).
- `FlushE`  out  1  clears ID/EX (inserts a NOP in execute).
- `StallD`  out  1  a hazard stall is in effect this cycle (status).
- `stall_cycles`  out  PERF_W  saturating count of stall cycles.

## Operation
- Scoreboard: one counter per register, `CNT_W = max(1, clog2(max(LOAD_LAT, MD_LAT)))` bits wide. Register 0 is never tracked and always reads 0.
- Long op in EX: `long_e = (MemReadE | MulDivE) & (RD_E != 0)`. The latency is `LAT = MemReadE ? LOAD_LAT : MD_LAT`. If both flags are set, `MemReadE` wins.
- Hazard on source rsX: `UseRsX_D & (rsX != 0) & ((long_e & RD_E == rsX) | (cnt[rsX] != 0))`.
- `hazard = hazard_rs1 | hazard_rs2`.
- Outputs are combinational, with priority in this order:
  - `rst`: `PCWrite=1`, `IF_ID_Write=1`, `FlushD=0`, `FlushE=0`, `StallD=0`.
  - `PCSrcE`: `PCWrite=1`, `IF_ID_Write=1`, `FlushD=1`, `FlushE=1`, `StallD=0`. The branch overrides any stall, because the stalled decode instruction is wrong-path.
  - `hazard`: `PCWrite=0`, `IF_ID_Write=0`, `FlushD=0`, `FlushE=1`, `StallD=1`.
  - Otherwise: `PCWrite=1`, `IF_ID_Write=1`, `FlushD=0`, `FlushE=0`, `StallD=0`.
- Counter update, every clock edge:
  - If `long_e`, `cnt[RD_E] <= LAT-1`. A newer write to the same register overwrites the older countdown.
  - Every other nonzero counter decrements by 1. Counters stop at 0.
  - Branch flushes do not clear counters, because the tracked instructions are older than the branch.
- `stall_cycles` increments by 1 on each edge where `StallD=1`. It saturates at 2^PERF_W−1.
- With `LOAD_LAT=1` and `MD_LAT=1` the block is behaviourally identical to a classic one-bubble load-use detector.

## Timing
- Reset: all counters and `stall_cycles` become 0 on the first edge with `rst=1`. Outputs take their no-hazard values while `rst` is high.
- Asserting `rst` mid-countdown drops all pending entries.
- A dependent decode instruction is held for exactly `LAT` cycles after its producer enters EX:
  - Cycle t: producer in EX, so the `long_e` match stalls.
  - Cycles t+1 through t+LAT−1: the counter is nonzero, so decode stalls.
  - Cycle t+LAT: the instruction proceeds and takes its operand from forwarding.
- The bubbles inserted via `FlushE` have `MemReadE=0` and `MulDivE=0`, so they create no entries.
- An independent instruction (no source match) never stalls, even while other counters are running.
- If both sources hit different pending registers, the stall lasts until the later of the two counters expires.
- Zero added latency: the outputs depend on the current inputs and the current counter state only.

## Test plan
- Classic case, `LOAD_LAT=1`: a load x5 in EX with an add reading x5 in decode gives one cycle of `PCWrite=0`, `IF_ID_Write=0`, `FlushE=1`, then release. `stall_cycles` = 1.
- `LOAD_LAT=3`: a load x7 followed by a dependent `sub x8,x7,x1` gives exactly 3 stall cycles. `cnt[7]` reads 2, 1, 0. `stall_cycles` = 3.
- `MD_LAT=3`, mul x9 in EX, dependent instruction uses only Rs2=x9 with `UseRs1_D=0` and Rs1=x9 as garbage: 3 stalls. Repeating with `UseRs2_D=0` as well gives 0 stalls.
- x0 destination: a load with `RD_E=0` and decode Rs1=0 gives no stall and no counter set.
- Branch override: `cnt[4]=2` with decode reading x4 and `PCSrcE=1` in the same cycle gives `FlushD=1`, `FlushE=1`, `PCWrite=1`, `StallD=0`. The next cycle `cnt[4]=1`.
- Overwrite and reset: a mul x3 (`MD_LAT=3`) followed next cycle by a load x3 (`LOAD_LAT=1`) sets `cnt[3]=0` on load issue. Separately, `rst` asserted while `cnt[6]=2` gives all counters 0, `stall_cycles`=0 and no stall on the next cycle.
